fust_scoreboard: RTL
====================

// Module: fust_scoreboard
// PURPOSE
//  Parametrised functional-unit status table (FUST) plus register result-status table for the scoreboard.
//  Generalises the fixed scalar/matrix FUST rows to N FUs, S source operands and 2^REG_W registers.
//  Tracks producer tags, wakes sources on writeback, and enforces structural, WAW and WAR hazards.
//  Sits between dispatch and the per-FU issue/writeback logic; the scalar and matrix cores each instantiate one.
// PARAMETERS
//  NUM_FU   4  number of functional units (rows)
//  NUM_SRC  2  source operands per row (3 for the matrix core)
//  REG_W    5  register index width; 2**REG_W architectural registers
//  ZERO_REG 1  1: register 0 is hardwired (never tracked, never a dependency)
//  TAG_W    $clog2(NUM_FU+1)  derived; tag 0 = value ready, tag k = produced by FU k-1
// PORTS
//  CLK             in   1                 clock
//  RST             in   1                 asynchronous reset, active-high
//  flush           in   1                 synchronous clear of all state
//  disp_valid      in   1                 dispatch request
//  disp_fu         in   $clog2(NUM_FU)    target FU row
//  disp_rd_en      in   1                 instruction writes a destination
//  disp_rd         in   REG_W             destination register
//  disp_rs         in   NUM_SRC*REG_W     source registers, index s at [s*REG_W +: REG_W]
//  disp_ready      out  1                 dispatch accepted this cycle
//  issue_ack       in   NUM_FU            FU i has read its operands
//  wb_valid        in   1                 writeback request
//  wb_fu           in   $clog2(NUM_FU)    FU completing
//  wb_ready        out  NUM_FU            FU i may write back (no WAR hazard)
//  fu_busy         out  NUM_FU            row occupied
//  fu_issue_ready  out  NUM_FU            busy, not issued, all source tags 0
//  fu_rd           out  NUM_FU*REG_W      destination per row
//  fu_rs           out  NUM_FU*NUM_SRC*REG_W  sources per row
// BEHAVIOUR
//  Reset/flush: all rows busy=0, issued=0, tags=0, rd/rs=0; all reg-status entries 0; all outputs 0 except
//   wb_ready=all-ones. RST mid-operation takes effect immediately; flush wins over same-cycle disp/wb/issue.
//  disp_ready (comb, registered state only) = disp_valid & !busy[disp_fu] & !(disp_rd_en & rstat[disp_rd]!=0).
//  Accept (1 cycle): row <= busy=1, issued=0, rd, rs; tag[s] <= rstat[rs[s]], forced 0 if it equals the
//   same-cycle wb tag or rs[s]==0 with ZERO_REG; rstat[rd] <= disp_fu+1 if rd_en and not (rd==0 & ZERO_REG).
//  Dispatch to an FU being written back in the same cycle is refused (busy still 1); retry next cycle.
//  issue_ack[i] on a ready row sets issued; ack on a non-ready row is ignored (assertion in bench).
//  wb_ready[i] = 0 iff some row j!=i is busy & !issued with rs[s]==fu_rd[i] and tag[s]==0 (WAR).
//  wb accepted when wb_valid & busy[wb_fu] & wb_ready[wb_fu]: row busy=0; every tag==wb_fu+1 -> 0;
//   rstat[fu_rd[wb_fu]] -> 0 only if it still equals wb_fu+1. Otherwise ignored.
//  fu_issue_ready reflects registered state: earliest issue is the cycle after the wakeup edge.
//  Widths: tags TAG_W bits, no arithmetic beyond +1 on FU index; NUM_FU must be <= 2**TAG_W-1.
// STRUCTURE
//  types_pkg: fust_tag_t typedef, FUST_TAG_NONE='0 constant, fu_idx to tag conversion function.
//  Sub-module fust_reg_status: 2**REG_W x TAG_W table, 1 read per source + 1 for rd, set/clear ports.
//  Top: row array, wakeup compare (NUM_FU*NUM_SRC comparators), WAR matrix, dispatch/wb arbitration.
// TESTING
//  RAW: disp FU0 rd=3; disp FU1 rs0=3 -> FU1 tag0=1, issue_ready[1]=0; wb FU0 -> next cycle issue_ready[1]=1.
//  WAW: FU0 writes x5 pending; disp FU2 rd=5 -> disp_ready=0 until FU0 wb, then accepted, rstat[5]=3.
//  WAR: FU1 unissued reads x7 (tag 0); FU0 rd=7 done -> wb_ready[0]=0; issue_ack[1] -> wb_ready[0]=1.
//  Same-cycle: wb FU0(rd=4) with disp FU2 rs0=4 -> FU2 tag0=0; disp to FU0 same cycle -> disp_ready=0.
//  x0: disp rd=0, rs=0 with ZERO_REG=1 -> rstat untouched, tags 0, issue_ready next cycle.
//  Flush/RST with 4 busy rows -> all fu_busy=0, rstat all 0, dispatch to any FU accepted next cycle.

Source files
------------

// File: rtl/fust_scoreboard_pkg.sv
// Shared types for the functional-unit status table.
//  fust_tag_t    : producer tag, wide enough for any supported FU count;
//                  instances truncate to their own TAG_W.
//  FUST_TAG_NONE : tag value meaning "operand value is ready".
//  fu_to_tag     : FU index k -> tag k+1 (tag 0 is reserved for "ready").
package fust_scoreboard_pkg;

  localparam int unsigned FUST_TAG_W_MAX = 8;

  typedef logic [FUST_TAG_W_MAX-1:0] fust_tag_t;

  localparam fust_tag_t FUST_TAG_NONE = '0;

  function automatic fust_tag_t fu_to_tag(input int unsigned fu_idx);
    return fust_tag_t'(fu_idx + 1);
  endfunction

endpackage

// File: rtl/fust_reg_status.sv
// Register result-status table: one producer tag per architectural register.
// Ports:
//  CLK, RST   clock, asynchronous active-high reset
//  clear      synchronous clear of every entry
//  rd_addr    NUM_RD packed read addresses (port p at [p*REG_W +: REG_W])
//  rd_tag     NUM_RD packed read results   (port p at [p*TAG_W +: TAG_W])
//  set_en/set_addr/set_tag   write set_tag into set_addr
//  clr_en/clr_addr/clr_tag   zero clr_addr only if it still holds clr_tag
module fust_reg_status
  import fust_scoreboard_pkg::*;
#(
  parameter int unsigned REG_W  = 5,
  parameter int unsigned TAG_W  = 3,
  parameter int unsigned NUM_RD = 3
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      clear,
  input  logic [NUM_RD*REG_W-1:0]   rd_addr,
  output logic [NUM_RD*TAG_W-1:0]   rd_tag,
  input  logic                      set_en,
  input  logic [REG_W-1:0]          set_addr,
  input  logic [TAG_W-1:0]          set_tag,
  input  logic                      clr_en,
  input  logic [REG_W-1:0]          clr_addr,
  input  logic [TAG_W-1:0]          clr_tag
);

  localparam int unsigned NUM_REGS = 2**REG_W;
  localparam logic [TAG_W-1:0] TAG_NONE = TAG_W'(FUST_TAG_NONE);

  logic [TAG_W-1:0] stat [NUM_REGS];

  always_comb begin
    rd_tag = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      rd_tag[p*TAG_W +: TAG_W] = stat[rd_addr[p*REG_W +: REG_W]];
    end
  end

  // A new producer claiming a register overrides a stale clear of the same
  // entry, so the set is applied after the conditional clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) stat[r] <= TAG_NONE;
    end else if (clear) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) stat[r] <= TAG_NONE;
    end else begin
      if (clr_en && (stat[clr_addr] == clr_tag)) stat[clr_addr] <= TAG_NONE;
      if (set_en) stat[set_addr] <= set_tag;
    end
  end

endmodule

// File: rtl/fust_scoreboard.sv
// Functional-unit status table (FUST) plus register result-status table.
// Tracks per-FU producer tags for each source operand, wakes sources on
// writeback and enforces structural (busy row), WAW (pending destination)
// and WAR (unissued reader of the destination) hazards.
// Ports:
//  CLK, RST        clock, asynchronous active-high reset
//  flush           synchronous clear of all state (beats disp/wb/issue)
//  disp_*          dispatch request: target FU, destination, sources
//  disp_ready      dispatch accepted this cycle
//  issue_ack       per FU: operands have been read
//  wb_valid/wb_fu  writeback request from one FU
//  wb_ready        per FU: writeback allowed (no WAR hazard)
//  fu_busy         per FU: row occupied
//  fu_issue_ready  per FU: busy, not yet issued, every source tag ready
//  fu_rd, fu_rs    destination / sources held in each row
module fust_scoreboard
  import fust_scoreboard_pkg::*;
#(
  parameter  int unsigned NUM_FU   = 4,
  parameter  int unsigned NUM_SRC  = 2,
  parameter  int unsigned REG_W    = 5,
  parameter  int unsigned ZERO_REG = 1,
  localparam int unsigned TAG_W    = $clog2(NUM_FU + 1),
  localparam int unsigned FU_W     = $clog2(NUM_FU)
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            flush,
  input  logic                            disp_valid,
  input  logic [FU_W-1:0]                 disp_fu,
  input  logic                            disp_rd_en,
  input  logic [REG_W-1:0]                disp_rd,
  input  logic [NUM_SRC*REG_W-1:0]        disp_rs,
  output logic                            disp_ready,
  input  logic [NUM_FU-1:0]               issue_ack,
  input  logic                            wb_valid,
  input  logic [FU_W-1:0]                 wb_fu,
  output logic [NUM_FU-1:0]               wb_ready,
  output logic [NUM_FU-1:0]               fu_busy,
  output logic [NUM_FU-1:0]               fu_issue_ready,
  output logic [NUM_FU*REG_W-1:0]         fu_rd,
  output logic [NUM_FU*NUM_SRC*REG_W-1:0] fu_rs
);

  localparam int unsigned NUM_RD = NUM_SRC + 1;
  localparam logic [TAG_W-1:0] TAG_NONE = TAG_W'(FUST_TAG_NONE);

  logic [NUM_FU-1:0] busy;
  logic [NUM_FU-1:0] issued;
  logic [REG_W-1:0]  rd_q  [NUM_FU];
  logic [REG_W-1:0]  rs_q  [NUM_FU][NUM_SRC];
  logic [TAG_W-1:0]  tag_q [NUM_FU][NUM_SRC];

  logic [NUM_RD*TAG_W-1:0] stat_rd;
  logic [TAG_W-1:0]        rd_stat;
  logic [TAG_W-1:0]        disp_tag;
  logic [TAG_W-1:0]        wb_tag;
  logic [TAG_W-1:0]        disp_src_tag [NUM_SRC];
  logic                    rd_tracked;
  logic                    wb_fire;

  assign disp_tag   = TAG_W'(fu_to_tag(disp_fu));
  assign wb_tag     = TAG_W'(fu_to_tag(wb_fu));
  assign rd_stat    = stat_rd[NUM_SRC*TAG_W +: TAG_W];
  assign rd_tracked = disp_rd_en && !((ZERO_REG != 0) && (disp_rd == '0));

  // Decisions depend on registered state only; a row being written back this
  // cycle still reads busy, so dispatch to it is refused until next cycle.
  assign disp_ready = disp_valid && !busy[disp_fu] &&
                      !(disp_rd_en && (rd_stat != TAG_NONE));
  assign wb_fire    = wb_valid && busy[wb_fu] && wb_ready[wb_fu];

  // Source tags captured at dispatch bypass a same-cycle writeback and the
  // hardwired zero register.
  always_comb begin
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      disp_src_tag[s] = stat_rd[s*TAG_W +: TAG_W];
      if (wb_fire && (disp_src_tag[s] == wb_tag)) disp_src_tag[s] = TAG_NONE;
      if ((ZERO_REG != 0) && (disp_rs[s*REG_W +: REG_W] == '0)) disp_src_tag[s] = TAG_NONE;
    end
  end

  // WAR: FU i must wait while another unissued row still has to read the
  // old value of i's destination (its tag is 0, i.e. it wants the current value).
  always_comb begin
    wb_ready = '1;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      for (int unsigned j = 0; j < NUM_FU; j++) begin
        if ((j != i) && busy[j] && !issued[j]) begin
          for (int unsigned s = 0; s < NUM_SRC; s++) begin
            if ((rs_q[j][s] == rd_q[i]) && (tag_q[j][s] == TAG_NONE)) wb_ready[i] = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    fu_issue_ready = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      fu_issue_ready[i] = busy[i] && !issued[i];
      for (int unsigned s = 0; s < NUM_SRC; s++) begin
        if (tag_q[i][s] != TAG_NONE) fu_issue_ready[i] = 1'b0;
      end
    end
  end

  always_comb begin
    fu_rd = '0;
    fu_rs = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      fu_rd[i*REG_W +: REG_W] = rd_q[i];
      for (int unsigned s = 0; s < NUM_SRC; s++) begin
        fu_rs[(i*NUM_SRC+s)*REG_W +: REG_W] = rs_q[i][s];
      end
    end
  end

  assign fu_busy = busy;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy   <= '0;
      issued <= '0;
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        rd_q[i] <= '0;
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
          rs_q[i][s]  <= '0;
          tag_q[i][s] <= TAG_NONE;
        end
      end
    end else if (flush) begin
      busy   <= '0;
      issued <= '0;
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        rd_q[i] <= '0;
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
          rs_q[i][s]  <= '0;
          tag_q[i][s] <= TAG_NONE;
        end
      end
    end else begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        if (issue_ack[i] && fu_issue_ready[i]) issued[i] <= 1'b1;
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
          if (wb_fire && (tag_q[i][s] == wb_tag)) tag_q[i][s] <= TAG_NONE;
        end
      end
      if (wb_fire) busy[wb_fu] <= 1'b0;
      // disp_fu != wb_fu whenever both fire, so these never collide.
      if (disp_ready) begin
        busy[disp_fu]   <= 1'b1;
        issued[disp_fu] <= 1'b0;
        rd_q[disp_fu]   <= disp_rd;
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
          rs_q[disp_fu][s]  <= disp_rs[s*REG_W +: REG_W];
          tag_q[disp_fu][s] <= disp_src_tag[s];
        end
      end
    end
  end

  fust_reg_status #(
    .REG_W  (REG_W),
    .TAG_W  (TAG_W),
    .NUM_RD (NUM_RD)
  ) u_reg_status (
    .CLK      (CLK),
    .RST      (RST),
    .clear    (flush),
    .rd_addr  ({disp_rd, disp_rs}),
    .rd_tag   (stat_rd),
    .set_en   (disp_ready && rd_tracked && !flush),
    .set_addr (disp_rd),
    .set_tag  (disp_tag),
    .clr_en   (wb_fire),
    .clr_addr (rd_q[wb_fu]),
    .clr_tag  (wb_tag)
  );

endmodule
